// File: rtl/joy_db15_pkg.sv
// Shared definitions for the DB15 serial joystick link.
// Used by the device-side shifter and the host-side decoder.
package joy_db15_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_FRAME_BITS = 32;

    // Bit positions inside one 16-bit player word (active-high buttons).
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_A     = 4;
    localparam int BTN_B     = 5;
    localparam int BTN_C     = 6;
    localparam int BTN_X     = 7;
    localparam int BTN_Y     = 8;
    localparam int BTN_Z     = 9;
    localparam int BTN_L     = 10;
    localparam int BTN_S     = 11;
    localparam int BTN_F     = 12;
    localparam int BTN_E     = 13;
    localparam int BTN_D     = 14;
    localparam int BTN_C_ALT = 15;

endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// Multi-flop synchronizer for an idle-high asynchronous line, plus
// single-cycle rise/fall pulses derived from the synchronized level.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/joy_db15_tx.sv
// Device end of the DB15 joystick link: snapshots two player words while
// load is low and shifts them out on rising host clock edges.
module joy_db15_tx
    import joy_db15_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = DEFAULT_FRAME_BITS,
    parameter int TIMEOUT     = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        joy_load,
    input  logic        joy_clk,
    input  logic [15:0] joystick1,
    input  logic [15:0] joystick2,
    output logic        joy_data,
    output logic        frame_done,
    output logic        busy
);

    localparam int CNT_W  = $clog2(FRAME_BITS);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
    localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(TIMEOUT);

    logic load_lvl, load_rise, load_fall;
    logic clk_lvl, clk_rise, clk_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_load_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (joy_load),
        .level   (load_lvl),
        .rise    (load_rise),
        .fall    (load_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (joy_clk),
        .level   (clk_lvl),
        .rise    (clk_rise),
        .fall    (clk_fall)
    );

    // Load acts on its level and the shift clock only on its rising edge.
    logic unused_edges;
    assign unused_edges = load_fall ^ clk_fall ^ clk_lvl;

    state_t                 state_q, state_d;
    logic [FRAME_BITS-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic                   joy_data_q, joy_data_d;
    logic                   frame_done_q, frame_done_d;
    logic                   busy_q, busy_d;

    // NOTE: every combinational output gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        idle_d       = idle_q;
        joy_data_d   = joy_data_q;
        frame_done_d = 1'b0;

        if (!load_lvl) begin
            // Load overrides everything, including a coincident clock edge.
            state_d    = ST_LATCH;
            sr_d       = ~{joystick2, joystick1};
            cnt_d      = '0;
            idle_d     = '0;
            joy_data_d = ~joystick1[0];
        end else begin
            case (state_q)
                ST_LATCH: begin
                    if (load_rise) begin
                        state_d = ST_SHIFT;
                        idle_d  = '0;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        sr_d   = {1'b1, sr_q[FRAME_BITS-1:1]};
                        idle_d = '0;
                        if (cnt_q == LAST_BIT) begin
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                            joy_data_d   = 1'b1;
                        end else begin
                            cnt_d      = cnt_q + CNT_W'(1);
                            joy_data_d = sr_q[1];
                        end
                    end else if (idle_q == IDLE_LAST) begin
                        // Host went quiet: drop the frame and park the line high.
                        state_d    = ST_IDLE;
                        idle_d     = IDLE_SAT;
                        sr_d       = '1;
                        joy_data_d = 1'b1;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
                default: begin
                    if (clk_rise) begin
                        sr_d       = {1'b1, sr_q[FRAME_BITS-1:1]};
                        joy_data_d = 1'b1;
                    end
                end
            endcase
        end

        busy_d = (state_d == ST_LATCH) || (state_d == ST_SHIFT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            sr_q         <= '1;
            cnt_q        <= '0;
            idle_q       <= '0;
            joy_data_q   <= 1'b1;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            joy_data_q   <= joy_data_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
        end
    end

    assign joy_data   = joy_data_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: table of full frames plus hand-written
// restart, timeout, reset and load/clock collision sequences.
module tb_joy_db15_tx;
    import joy_db15_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        joy_load;
    logic        joy_clk;
    logic [15:0] joystick1;
    logic [15:0] joystick2;
    logic        joy_data;
    logic        frame_done;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int done_total = 0;

    joy_db15_tx dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .joy_load   (joy_load),
        .joy_clk    (joy_clk),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .joy_data   (joy_data),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) done_total <= done_total + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] j1_pre;
        logic [15:0] j1;
        logic [15:0] j1_post;
        logic [15:0] j2;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] pre, input logic [15:0] j1,
                           input logic [15:0] post, input logic [15:0] j2);
        joystick1 = pre;
        joystick2 = j2;
        joy_load  = 1'b0;
        cyc(4);
        joystick1 = j1;
        cyc(6);
        joy_load = 1'b1;
        cyc(3);
        joystick1 = post;
        cyc(4);
    endtask

    // Samples the current bit, then gives one full host clock period.
    task automatic shift_bits(input int n, output logic [31:0] got,
                              output int early, output int total);
        int start;
        start = done_total;
        got   = '0;
        early = 0;
        for (int i = 0; i < n; i++) begin
            cyc(6);
            got[i] = joy_data;
            if (i == n - 1) early = done_total - start;
            joy_clk = 1'b1;
            cyc(6);
            joy_clk = 1'b0;
        end
        cyc(6);
        total = done_total - start;
    endtask

    initial begin
        logic [31:0] got;
        int          early;
        int          total;
        int          start;

        vecs[0] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000, 32'h7FFF_FFFE};
        vecs[1] = '{16'h0000, 16'h0001 << BTN_A, 16'h0000, 16'h0000, 32'hFFFF_FFEF};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 32'hFFFF_0000};
        vecs[3] = '{16'hA5A5, 16'hA5A5, 16'hA5A5, 16'h3C3C, 32'hC3C3_5A5A};
        vecs[4] = '{16'h1234, 16'h1234, 16'h1234, 16'hFEDC, 32'h0123_EDCB};
        vecs[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'hFFFF_FFFF};

        reset_n   = 1'b0;
        joy_load  = 1'b1;
        joy_clk   = 1'b0;
        joystick1 = '0;
        joystick2 = '0;
        cyc(3);
        check("reset_joy_data", {31'd0, joy_data}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        reset_n = 1'b1;
        cyc(5);

        for (int v = 0; v < 6; v++) begin
            do_load(vecs[v].j1_pre, vecs[v].j1, vecs[v].j1_post, vecs[v].j2);
            if (v == 0) check("busy_in_shift", {31'd0, busy}, 32'd1);
            shift_bits(32, got, early, total);
            check($sformatf("vec%0d_stream", v), got, vecs[v].exp);
            check($sformatf("vec%0d_done_early", v), early, 0);
            check($sformatf("vec%0d_done_count", v), total, 1);
            check($sformatf("vec%0d_idle_data", v), {31'd0, joy_data}, 32'd1);
            check($sformatf("vec%0d_idle_busy", v), {31'd0, busy}, 32'd0);
        end

        // Reload ten bits into a frame: counter restarts, one frame_done total.
        start = done_total;
        do_load(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        shift_bits(10, got, early, total);
        do_load(vecs[3].j1_pre, vecs[3].j1, vecs[3].j1_post, vecs[3].j2);
        shift_bits(32, got, early, total);
        check("restart_stream", got, vecs[3].exp);
        check("restart_done_count", done_total - start, 1);

        // Host stops after five clocks; bit 5 is a 0 so the timeout is visible.
        start = done_total;
        do_load(16'h0020, 16'h0020, 16'h0020, 16'h0000);
        shift_bits(5, got, early, total);
        check("timeout_pre_data", {31'd0, joy_data}, 32'd0);
        cyc(4000);
        check("timeout_still_busy", {31'd0, busy}, 32'd1);
        cyc(150);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        check("timeout_data", {31'd0, joy_data}, 32'd1);
        check("timeout_no_done", done_total - start, 0);
        shift_bits(3, got, early, total);
        check("timeout_after_clocks", got, 32'h0000_0007);
        check("timeout_after_no_done", total, 0);

        // Asynchronous reset in the middle of a frame.
        do_load(vecs[4].j1_pre, vecs[4].j1, vecs[4].j1_post, vecs[4].j2);
        shift_bits(7, got, early, total);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #2;
        check("async_reset_data", {31'd0, joy_data}, 32'd1);
        check("async_reset_busy", {31'd0, busy}, 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(4);
        do_load(vecs[0].j1_pre, vecs[0].j1, vecs[0].j1_post, vecs[0].j2);
        shift_bits(32, got, early, total);
        check("post_reset_stream", got, vecs[0].exp);
        check("post_reset_done_count", total, 1);

        // Load fall and clock rise reach the synchronizers together.
        joystick1 = 16'h0001;
        joystick2 = 16'h0000;
        joy_load  = 1'b0;
        joy_clk   = 1'b1;
        cyc(8);
        joy_load = 1'b1;
        cyc(6);
        check("collide_bit0", {31'd0, joy_data}, 32'd0);
        joy_clk = 1'b0;
        cyc(6);
        shift_bits(32, got, early, total);
        check("collide_stream", got, 32'hFFFF_FFFE);
        check("collide_done_count", total, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/joy_db15_tx.md
# joy_db15_tx

Device-side model of the DB15 serial joystick adapter: latches two 16-bit player button words on a host load strobe and shifts them out bit-serially on the host's shift clock. It is the responder end of the USER_IO DB15 link whose host end drives JOY_LOAD/JOY_CLK and samples JOY_DATA. It is used as a loopback target for bench and board bring-up, and as the core of an FPGA-based adapter.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on joy_load and joy_clk (≥2).
- FRAME_BITS, 32: bits per frame. Player 1 word, then player 2 word.
- TIMEOUT, 4096: clk cycles in SHIFT with no joy_clk rising edge before the block abandons the frame.

Ports:
- clk  in  1  system clock, 48 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- joy_load  in  1  host latch strobe, active-low, asynchronous to clk.
- joy_clk  in  1  host shift clock, asynchronous to clk; shifting happens on its rising edge.
- joystick1  in  16  player 1 buttons, active-high, bit map R,L,D,U,A,B,C,X,Y,Z,L,S,F,E,D,C in bits [0..15].
- joystick2  in  16  player 2 buttons, same map.
- joy_data  out  1  serial data, active-low on the wire. Idle level is 1.
- frame_done  out  1  one-clk pulse after bit FRAME_BITS-1 has been shifted past.
- busy  out  1  high in LATCH or SHIFT.

## Operation
- Inputs joy_load and joy_clk each pass through a SYNC_STAGES flop chain, followed by a 1-flop edge detector.
- State machine states: IDLE, LATCH, SHIFT, DONE.
  - Any state, synced load = 0 → LATCH. In LATCH, every clk cycle: sr ← ~{joystick2, joystick1}, cnt ← 0, joy_data ← ~joystick1[0]. The snapshot keeps tracking the inputs while load is low.
  - LATCH, load rises → SHIFT. The snapshot is frozen.
  - SHIFT, joy_clk rising edge → sr ← {1'b1, sr[FRAME_BITS-1:1]}, cnt ← cnt+1, joy_data ← sr[1]. When cnt reaches FRAME_BITS-1 → DONE, frame_done = 1 for one cycle, and joy_data = 1.
  - SHIFT, idle counter reaches TIMEOUT → IDLE, joy_data = 1. There is no frame_done pulse.
  - DONE / IDLE: further joy_clk edges shift in 1s, so joy_data stays 1.
- joy_clk edges while load is low are ignored, because load overrides shift (74HC165 behaviour).
- Simultaneous synced load fall and clk rise: load wins.
- The idle counter resets on every clk edge and on LATCH entry. It saturates and does not wrap.
- cnt width is $clog2(FRAME_BITS). cnt never wraps; DONE is terminal until the next load.
- Reset mid-frame: all state clears asynchronously. joy_data = 1, frame_done = 0, busy = 0, state = IDLE, sr = all 1s, cnt = 0.

## Timing
- Pin edge to joy_data update: SYNC_STAGES+1 clk cycles (3 at default).
- Hosts must hold each joy_clk phase ≥ SYNC_STAGES+2 clk cycles (≥84 ns at 48 MHz). A host sampling on the falling edge then sees stable data.
- joy_load low pulse must be ≥ SYNC_STAGES+2 clk cycles.
- Bit 0 is valid on joy_data SYNC_STAGES+1 cycles after the load fall, i.e. before the first joy_clk.
- frame_done asserts SYNC_STAGES+1 cycles after the joy_clk rising edge that consumes the last bit.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package joy_db15_pkg holds:
  - state enum, 2 bits (IDLE=0, LATCH=1, SHIFT=2, DONE=3);
  - button bit-index constants shared with the host-side decoder;
  - default FRAME_BITS.
- One sub-module, sync_edge: parameterised synchronizer plus rise/fall pulse outputs, reset to 1 (idle-high lines). It is instantiated for joy_load and joy_clk.

## Test plan
- joystick1=16'h0001, joystick2=16'h8000; load pulse, then 32 clocks → sampled joy_data stream is 0 followed by 30 ones, with 0 at bit 31. frame_done pulses once, after clock 32.
- joystick1 changes from 16'h0000 to 16'h0010 while load is low, then load rises → bit 4 sampled as 0. An input change after load rises (to 16'h0000) does not affect the frame.
- Load asserted after 10 clocks of a frame → cnt restarts. The next 32 clocks deliver the freshly latched frame, and frame_done fires exactly once.
- Load pulse, 5 clocks, then silence for 4096 cycles → busy drops and joy_data = 1, with no frame_done. Further clocks keep joy_data at 1.
- reset_n pulled low mid-shift, asynchronously to clk → joy_data = 1 and busy = 0 in the same cycle. After release, a normal frame works.
- joy_clk rises on the same synced cycle as load falls → no shift occurs, and bit 0 of the new snapshot is on joy_data.
